// File: rtl/arb_req_frontend.sv
// arb_req_frontend: requester-side front end for a 4-way round-robin arbiter.
// Four per-port FIFOs drive req toward the arbiter; the registered one-hot gnt
// pops the granted head onto one shared registered output bus. Grants that hit
// an empty queue are counted in stale_cnt; multi-hot grants set gnt_err.
// Optional macro ARB_REQ_LAST_MASK_EN: drop req in the cycle a port's last
// entry is being granted, so the arbiter cannot issue a stale follow-up grant.
module arb_req_frontend #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [4*DW-1:0]  in_data,
    output logic [3:0]       in_ready,
    output logic [3:0]       req,
    input  logic [3:0]       gnt,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [1:0]       out_src,
    output logic [CNT_W-1:0] stale_cnt,
    output logic             gnt_err
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] mem   [4][DEPTH];
    logic [PW-1:0] rptr  [4];
    logic [PW-1:0] wptr  [4];
    logic [CW-1:0] count [4];

    logic [1:0] sel;
    logic [3:0] push;
    logic [3:0] pop;
    logic       stale;
    logic       multi;

    // Lowest set grant bit selects the serviced port.
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (gnt[i]) sel = 2'(i);
        end
    end

    assign multi = (gnt & (gnt - 4'd1)) != 4'd0;
    assign stale = (gnt != 4'd0) && (count[sel] == '0);

    // Per-port ready, push/pop decode and request generation.
    always_comb begin
        in_ready = 4'b0000;
        push     = 4'b0000;
        pop      = 4'b0000;
        req      = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = (count[i] != FULL);
            push[i]     = in_valid[i] && (count[i] != FULL);
            pop[i]      = (gnt != 4'd0) && (sel == 2'(i)) && (count[i] != '0);
`ifdef ARB_REQ_LAST_MASK_EN
            req[i]      = (count[i] > CW'(1)) || ((count[i] == CW'(1)) && !gnt[i]);
`else
            req[i]      = (count[i] != '0);
`endif
        end
    end

    // Queue storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) mem[i][wptr[i]] <= in_data[i*DW +: DW];
        end
    end

    // Pointer and occupancy update; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rptr[i]  <= '0;
                wptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wptr[i] <= wptr[i] + PW'(1);
                if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
                if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (pop[i] && !push[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    // Registered output bus; stale grants leave data/src holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 2'd0;
        end else if (pop != 4'd0) begin
            out_valid <= 1'b1;
            out_data  <= mem[sel][rptr[sel]];
            out_src   <= sel;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Saturating stale-grant counter and sticky multi-hot grant flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt <= '0;
            gnt_err   <= 1'b0;
        end else begin
            if (stale && (stale_cnt != '1)) stale_cnt <= stale_cnt + CNT_W'(1);
            if (multi) gnt_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_frontend.sv
// Directed self-checking bench for arb_req_frontend (DW=8, DEPTH=2, CNT_W=8).
// The bench plays the arbiter, driving gnt directly one cycle after req.
module tb_arb_req_frontend;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic [7:0]  stale_cnt;
    logic        gnt_err;

    int n_checks = 0;
    int n_fail   = 0;

    arb_req_frontend #(.DW(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .stale_cnt (stale_cnt),
        .gnt_err   (gnt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".src"},   32'(out_src),   32'(s));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 4'b0000;
        in_data  = 32'h0;
        gnt      = 4'b0000;
        tick();
        tick();

        // Reset state.
        check("rst.req",       32'(req),       32'h0);
        check("rst.in_ready",  32'(in_ready),  32'hF);
        check("rst.out_valid", 32'(out_valid), 32'h0);
        check("rst.out_data",  32'(out_data),  32'h0);
        check("rst.out_src",   32'(out_src),   32'h0);
        check("rst.stale_cnt", 32'(stale_cnt), 32'h0);
        check("rst.gnt_err",   32'(gnt_err),   32'h0);
        rst = 1'b0;
        tick();

        // Single push on port 2, one-cycle grant-to-output latency.
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        tick();
        in_valid = 4'b0000;
        check("p2.req", 32'(req), 32'h4);
        gnt = 4'b0100;
        tick();
        check_out("p2.out", 8'hA5, 2'd2);
        check("p2.req_empty", 32'(req), 32'h0);
        gnt = 4'b0000;
        tick();
        check("p2.idle", 32'(out_valid), 32'h0);

        // Fill port 0, third push held while full, FIFO order on drain.
        in_valid = 4'b0001;
        in_data  = 32'h0000_0011;
        tick();
        in_data  = 32'h0000_0022;
        tick();
        check("full.in_ready", 32'(in_ready), 32'hE);
        in_data  = 32'h0000_0033;
        tick();
        check("full.held", 32'(in_ready), 32'hE);
        gnt = 4'b0001;
        tick();
        in_valid = 4'b0000;
        check_out("full.out0", 8'h11, 2'd0);
        check("full.ready_back", 32'(in_ready), 32'hF);
        tick();
        check_out("full.out1", 8'h22, 2'd0);
        check("full.drained", 32'(req), 32'h0);
        gnt = 4'b0000;
        tick();
        check("full.idle", 32'(out_valid), 32'h0);

        // One entry on every port, rotating grants.
        in_valid = 4'b1111;
        in_data  = 32'h4030_2010;
        tick();
        in_valid = 4'b0000;
        check("rr.req", 32'(req), 32'hF);
        gnt = 4'b0001;
        tick();
        check_out("rr.g0", 8'h10, 2'd0);
        gnt = 4'b0010;
        tick();
        check_out("rr.g1", 8'h20, 2'd1);
        gnt = 4'b0100;
        tick();
        check_out("rr.g2", 8'h30, 2'd2);
        gnt = 4'b1000;
        tick();
        check_out("rr.g3", 8'h40, 2'd3);
        gnt = 4'b0000;
        tick();
        check("rr.idle", 32'(out_valid), 32'h0);
        check("rr.req_empty", 32'(req), 32'h0);

        // Grant held two cycles on a single-entry queue.
        in_valid = 4'b0010;
        in_data  = 32'h0000_5500;
        tick();
        in_valid = 4'b0000;
        gnt = 4'b0010;
        #1;
`ifdef ARB_REQ_LAST_MASK_EN
        check("last.req_masked", 32'(req[1]), 32'h0);
`else
        check("last.req_live", 32'(req[1]), 32'h1);
`endif
        tick();
        check_out("last.out", 8'h55, 2'd1);
        check("last.stale0", 32'(stale_cnt), 32'h0);
        tick();
        check("stale.valid", 32'(out_valid), 32'h0);
        check("stale.cnt",   32'(stale_cnt), 32'h1);
        check("stale.data",  32'(out_data),  32'h55);
        check("stale.src",   32'(out_src),   32'h1);
        gnt = 4'b0000;
        tick();
        check("stale.cnt_hold", 32'(stale_cnt), 32'h1);

        // Multi-hot grant services lowest bit and sets sticky error.
        in_valid = 4'b0110;
        in_data  = 32'h0062_6100;
        tick();
        in_valid = 4'b0000;
        check("multi.err_clear", 32'(gnt_err), 32'h0);
        gnt = 4'b0110;
        tick();
        check_out("multi.out", 8'h61, 2'd1);
        check("multi.err", 32'(gnt_err), 32'h1);
        gnt = 4'b0000;
        tick();
        check("multi.p2_kept", 32'(req), 32'h4);
        check("multi.err_sticky", 32'(gnt_err), 32'h1);
        gnt = 4'b0100;
        tick();
        check_out("multi.p2", 8'h62, 2'd2);
        gnt = 4'b0000;
        tick();
        check("multi.err_sticky2", 32'(gnt_err), 32'h1);

        // Asynchronous reset mid-operation with entries queued.
        in_valid = 4'b1001;
        in_data  = 32'h7300_0071;
        tick();
        in_valid = 4'b0000;
        gnt = 4'b0001;
        tick();
        check_out("ar.pre", 8'h71, 2'd0);
        gnt = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("ar.valid",     32'(out_valid), 32'h0);
        check("ar.data",      32'(out_data),  32'h0);
        check("ar.src",       32'(out_src),   32'h0);
        check("ar.stale_cnt", 32'(stale_cnt), 32'h0);
        check("ar.gnt_err",   32'(gnt_err),   32'h0);
        check("ar.req",       32'(req),       32'h0);
        check("ar.in_ready",  32'(in_ready),  32'hF);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("ar.post_valid", 32'(out_valid), 32'h0);
        check("ar.post_req",   32'(req),       32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
